// File: rtl/sort9_pkg.sv
// rtl/sort9_pkg.sv - shared types, sizes and packing helper for the sort9 sequencer
package sort9_pkg;

    localparam int N_ELEM      = 9;
    localparam int ELEM_W      = 4;
    localparam int READ_CYCLES = N_ELEM + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_PROCESSING,
        ST_MEM_WRITE,
        ST_DONE
    } state_t;

    function automatic logic [ELEM_W-1:0] elem(input logic [N_ELEM*ELEM_W-1:0] vec,
                                               input logic [3:0] k);
        logic [5:0] base;
        base = 6'(k) * 6'(ELEM_W);
        return vec[base +: ELEM_W];
    endfunction

endpackage

// File: rtl/sort9_seq_ctrl_if.sv
// rtl/sort9_seq_ctrl_if.sv - single-port synchronous RAM bus between sequencer and memory
interface sort9_seq_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [3:0]        mem_wdata;
    logic [3:0]        mem_rdata;

    modport master (output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rd_en, mem_wr_en, mem_wdata, output mem_rdata);
endinterface

// File: rtl/sort9_regbank.sv
// rtl/sort9_regbank.sv - 9x4 register bank: indexed write, parallel load, parallel read, sync clear
module sort9_regbank
    import sort9_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [3:0]               wr_idx,
    input  logic [ELEM_W-1:0]        wr_data,
    input  logic                     ld_en,
    input  logic [N_ELEM*ELEM_W-1:0] ld_data,
    output logic [N_ELEM*ELEM_W-1:0] rd_data
);
    logic [5:0] wr_base;

    assign wr_base = 6'(wr_idx) * 6'(ELEM_W);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            rd_data <= '0;
        end else if (ld_en) begin
            rd_data <= ld_data;
        end else if (wr_en && (wr_idx < 4'(N_ELEM))) begin
            rd_data[wr_base +: ELEM_W] <= wr_data;
        end
    end

endmodule

// File: rtl/sort9_seq_ctrl.sv
// rtl/sort9_seq_ctrl.sv - sort9 job sequencer: RAM read, sorter handoff, write-back; SORT9_ORDER_CHECK_EN adds order_err
module sort9_seq_ctrl
    import sort9_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int PROC_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        src_base,
    input  logic [ADDR_W-1:0]        dst_base,
    output logic                     busy,
    output logic                     done,
    sort9_seq_ctrl_if.master         mem,
    output logic [N_ELEM*ELEM_W-1:0] sort_in,
    input  logic [N_ELEM*ELEM_W-1:0] sort_out
`ifdef SORT9_ORDER_CHECK_EN
    ,
    output logic                     order_err
`endif
);
    state_t                   state, state_n;
    logic [3:0]               idx, idx_n;
    logic [3:0]               pcnt, pcnt_n;
    logic [ADDR_W-1:0]        src_q, dst_q;
    logic                     rd_vld;
    logic                     accept;
    logic                     capture;
    logic [N_ELEM*ELEM_W-1:0] result;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            pcnt   <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            rd_vld <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            pcnt   <= pcnt_n;
            rd_vld <= mem.mem_rd_en;
            if (accept) begin
                src_q <= src_base;
                dst_q <= dst_base;
            end
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        pcnt_n        = pcnt;
        accept        = 1'b0;
        capture       = 1'b0;
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_rd_en = 1'b0;
        mem.mem_wr_en = 1'b0;
        mem.mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_n   = '0;
                    pcnt_n  = '0;
                    state_n = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                // extra tail cycle lets the last read word land via rd_vld
                if (idx < 4'(N_ELEM)) begin
                    mem.mem_rd_en = 1'b1;
                    mem.mem_addr  = src_q + ADDR_W'(idx);
                end
                if (idx == 4'(READ_CYCLES - 1)) begin
                    idx_n   = '0;
                    state_n = ST_PROCESSING;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            ST_PROCESSING: begin
                if (pcnt == 4'(PROC_CYCLES - 1)) begin
                    capture = 1'b1;
                    pcnt_n  = '0;
                    state_n = ST_MEM_WRITE;
                end else begin
                    pcnt_n = pcnt + 4'd1;
                end
            end
            ST_MEM_WRITE: begin
                mem.mem_wr_en = 1'b1;
                mem.mem_addr  = dst_q + ADDR_W'(idx);
                mem.mem_wdata = elem(result, idx);
                if (idx == 4'(N_ELEM - 1)) begin
                    idx_n   = '0;
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    sort9_regbank u_operands (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .wr_en   (rd_vld),
        .wr_idx  (idx - 4'd1),
        .wr_data (mem.mem_rdata),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_data (sort_in)
    );

    sort9_regbank u_results (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .wr_en   (1'b0),
        .wr_idx  (4'd0),
        .wr_data ('0),
        .ld_en   (capture),
        .ld_data (sort_out),
        .rd_data (result)
    );

`ifdef SORT9_ORDER_CHECK_EN
    logic order_bad;

    always_comb begin
        order_bad = 1'b0;
        for (int k = 0; k < N_ELEM - 1; k++) begin
            if (elem(sort_out, 4'(k)) > elem(sort_out, 4'(k + 1))) begin
                order_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            order_err <= 1'b0;
        end else if (accept) begin
            order_err <= 1'b0;
        end else if (capture && order_bad) begin
            order_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/sort9_seq_ctrl.md
Name: sort9_seq_ctrl

Overview:
- Sequencer for the 9-element, 4-bit combinational sorting network.
- Reads 9 operands from a single-port synchronous RAM into an operand bank and drives the bank onto the sorter inputs.
- Captures the sorted outputs, writes them back to a destination region, then pulses done.
- Sits between the memory subsystem and the sorter instance; the parent instantiates both.

Parameters:
- ADDR_W, 8, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- PROC_CYCLES, 1, cycles spent in PROCESSING before sort_out is captured (range 1..15). Allows for a registered or retimed sorter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request one sort job; sampled only in IDLE.
- src_base  in  ADDR_W  first source address; sampled when start is accepted.
- dst_base  in  ADDR_W  first destination address; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  single-cycle pulse in DONE.
- mem_addr  out  ADDR_W  RAM address.
- mem_rd_en  out  1  RAM read strobe; read data is valid on mem_rdata one cycle later.
- mem_wr_en  out  1  RAM write strobe.
- mem_wdata  out  4  RAM write data.
- mem_rdata  in  4  RAM read data.
- sort_in  out  36  to sorter; element k on bits [4k+3:4k], where k=0 is the word read from src_base+0.
- sort_out  in  36  from sorter; bits [4k+3:4k] carry the k-th smallest value (k=0 = minimum).

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, operand bank=0, result bank=0, counters=0.
- Reset mid-job aborts the job; the RAM sees no further strobes after that edge.
- States, one-hot or encoded: IDLE, MEM_READ, PROCESSING, MEM_WRITE, DONE.
- IDLE:
  - start=1 latches the bases, clears idx, and moves to MEM_READ.
  - start=0 holds IDLE.
- MEM_READ lasts exactly 10 cycles (idx 0..9):
  - For idx 0..8: mem_rd_en=1 and mem_addr=src_base+idx.
  - At idx 9: mem_rd_en=0.
  - A delayed-valid flag writes mem_rdata into operand[idx-1] on idx 1..9.
  - After idx 9, go to PROCESSING.
- sort_in always reflects the operand bank. The bank is stable throughout PROCESSING.
- PROCESSING lasts PROC_CYCLES cycles. On the last cycle, sort_out is captured into the result bank. Then go to MEM_WRITE.
- MEM_WRITE lasts exactly 9 cycles (idx 0..8):
  - mem_wr_en=1, mem_addr=dst_base+idx, mem_wdata=result[idx].
  - Then go to DONE.
- DONE lasts 1 cycle with done=1, then returns to IDLE. busy drops in the same cycle as DONE exits.
- Latency: start accepted at cycle 0 → done at cycle 10+PROC_CYCLES+9+1 (21 with default parameters).
- mem_rd_en and mem_wr_en are never high together.
- start is ignored while busy, including start asserted in the same cycle as done.
- An address range crossing 2^ADDR_W-1 wraps to 0.
- Overlapping source and destination ranges are legal; all reads complete before the first write.

Optional Feature:
- Macro SORT9_ORDER_CHECK_EN.
- Defined:
  - Adds output order_err (1 bit, reset 0).
  - At capture, order_err is set if any adjacent result pair violates out[k] <= out[k+1] (unsigned).
  - order_err is sticky until the next accepted start or reset.
- Undefined: no port and no logic.

Decomposition:
- Package sort9_pkg holds:
  - state enum type;
  - N_ELEM=9, ELEM_W=4, READ_CYCLES=N_ELEM+1;
  - packing helper function elem(vec,k).
- One natural sub-module: sort9_regbank, a 9x4 register bank with indexed write, parallel 36-bit read and synchronous clear.
- The sorter itself stays outside this block.

Test Plan:
- Reset during MEM_READ (idx 4) → next cycle state=IDLE, all outputs 0, no further RAM strobes.
- RAM[0..8]={9,3,7,1,8,2,6,4,5}, src=0, dst=16, start → RAM[16..24]={1..9}, done exactly at cycle 21, busy high cycles 1..21.
- src=0xFC, dst=0xF9 → reads use addresses FC..FF then 00..04; writes use F9..FF then 00,01; sorted data correct.
- Duplicates {5,5,0,15,5,0,15,5,5} with PROC_CYCLES=3 → {0,0,5,5,5,5,5,15,15}, done at cycle 23.
- start held high through done → exactly one job; a start pulse while busy is ignored; re-start in IDLE runs a second job correctly.
- With SORT9_ORDER_CHECK_EN, the bench forces sort_out slot 3 > slot 4 → order_err=1 after capture; it clears on the next start.
